bits_unflatten: RTL and testbench

BITS_UNFLATTEN -- requirements
Module: bits_unflatten

---
 rtl/bits_unflatten_if.sv | 22 ++
 rtl/bits_unflatten.sv | 140 ++++++++++++++
 tb/tb_bits_unflatten.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/bits_unflatten_if.sv
// Serial-bit input and assembled-symbol output bundle for bits_unflatten.
interface bits_unflatten_if #(
  parameter int M = 8
);
  logic         bypass;
  logic         I;
  logic         I_vld;
  logic         I_sof;
  logic [M-1:0] O;
  logic         O_vld;
  logic         O_err;

  modport master (
    output bypass, I, I_vld, I_sof,
    input  O, O_vld, O_err
  );

  modport slave (
    input  bypass, I, I_vld, I_sof,
    output O, O_vld, O_err
  );
endinterface

// File: rtl/bits_unflatten.sv
// Collects N serial bits (first bit -> O[0]) into one registered symbol,
// with gap timeout, restart-on-sof error reporting and a BPSK bypass mode.
module bits_unflatten #(
  parameter int N                = 2,
  parameter int M                = 8,
  parameter int BYPASS_SELECTION = 1,
  parameter int GAP_MAX          = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  bits_unflatten_if.slave bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int GW = (GAP_MAX > 0) ? $clog2(GAP_MAX + 1) : 1;

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [N-1:0]    part_q, part_d;
  logic [M-1:0]    o_q, o_d;
  logic            vld_q, vld_d;
  logic            err_q, err_d;
  logic            last_bit;
  logic            gap_hit;

  assign last_bit = (cnt_q == CW'(N - 1));
  // The idle cycle that would bring the gap count to GAP_MAX ends the symbol.
  assign gap_hit  = (gap_q >= GW'(GAP_MAX - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      part_q  <= '0;
      o_q     <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      part_q  <= part_d;
      o_q     <= o_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.bypass) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.I_vld && bus.I_sof) state_d = COLLECT;
        COLLECT: begin
          if (bus.I_vld) begin
            if (!bus.I_sof && last_bit) state_d = IDLE;
          end else if (gap_hit) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    gap_d  = gap_q;
    part_d = part_q;
    o_d    = o_q;
    vld_d  = 1'b0;
    err_d  = 1'b0;
    if (bus.bypass) begin
      // Bypass drops any partial symbol silently.
      cnt_d  = '0;
      gap_d  = '0;
      part_d = '0;
      if (bus.I_vld) begin
        vld_d               = 1'b1;
        o_d                 = '0;
        o_d[BYPASS_SELECTION] = bus.I;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.I_vld && bus.I_sof) begin
            part_d    = '0;
            part_d[0] = bus.I;
            cnt_d     = CW'(1);
            gap_d     = '0;
          end
        end
        COLLECT: begin
          if (bus.I_vld) begin
            gap_d = '0;
            if (bus.I_sof) begin
              err_d     = 1'b1;
              part_d    = '0;
              part_d[0] = bus.I;
              cnt_d     = CW'(1);
            end else if (last_bit) begin
              vld_d        = 1'b1;
              o_d          = '0;
              o_d[N-1:0]   = part_q;
              o_d[N-1]     = bus.I;
              cnt_d        = '0;
              part_d       = '0;
            end else begin
              part_d[cnt_q] = bus.I;
              cnt_d         = cnt_q + CW'(1);
            end
          end else if (gap_hit) begin
            err_d  = 1'b1;
            cnt_d  = '0;
            gap_d  = '0;
            part_d = '0;
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
        default: begin
          cnt_d  = '0;
          gap_d  = '0;
          part_d = '0;
        end
      endcase
    end
  end

  assign bus.O     = o_q;
  assign bus.O_vld = vld_q;
  assign bus.O_err = err_q;

endmodule

// File: tb/tb_bits_unflatten.sv
// Randomised and directed bench for bits_unflatten against a queue-based symbol model.
module tb_bits_unflatten;

  localparam int N  = 2;
  localparam int M  = 8;
  localparam int BS = 1;
  localparam int GM = 15;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  bits_unflatten_if #(.M(M)) bus ();

  bits_unflatten #(
    .N(N),
    .M(M),
    .BYPASS_SELECTION(BS),
    .GAP_MAX(GM)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: bits of the symbol being gathered, idle-run length, expected outputs.
  bit         mq[$];
  int         mgap;
  logic [M-1:0] eo;
  bit         ev;
  bit         ee;

  function automatic void model_step(bit r, bit bp, bit v, bit s, bit i);
    ev = 1'b0;
    ee = 1'b0;
    if (!r) begin
      mq.delete();
      mgap = 0;
      eo   = '0;
      return;
    end
    if (bp) begin
      mq.delete();
      mgap = 0;
      if (v) begin
        ev = 1'b1;
        eo = i ? M'(1 << BS) : '0;
      end
      return;
    end
    if (mq.size() == 0) begin
      if (v && s) begin
        mq.push_back(i);
        mgap = 0;
      end
    end else if (v) begin
      mgap = 0;
      if (s) begin
        ee = 1'b1;
        mq.delete();
        mq.push_back(i);
      end else begin
        mq.push_back(i);
        if (mq.size() == N) begin
          ev = 1'b1;
          eo = '0;
          foreach (mq[k]) eo = eo | (M'(mq[k]) << k);
          mq.delete();
        end
      end
    end else begin
      mgap++;
      if (mgap >= GM) begin
        ee = 1'b1;
        mq.delete();
        mgap = 0;
      end
    end
  endfunction

  task automatic tick(input bit r, input bit bp, input bit v, input bit s, input bit i);
    @(negedge clk);
    rst_n      = r;
    bus.bypass = bp;
    bus.I_vld  = v;
    bus.I_sof  = s;
    bus.I      = i;
    model_step(r, bp, v, s, i);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b0, 1'b1, k[0], 1'b1);
      checks++;
      if ({bus.O, bus.O_vld, bus.O_err} !== {8'h00, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset cyc%0d: O=%h vld=%b err=%b, want O=00 vld=0 err=0",
                 k, bus.O, bus.O_vld, bus.O_err);
      end
    end
  endtask

  task automatic test_pairs();
    logic [2:0] seq   [4] = '{3'b111, 3'b100, 3'b110, 3'b101};
    logic [7:0] exp_o [4] = '{8'h00, 8'h01, 8'h01, 8'h02};
    bit         exp_v [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, 1'b0, seq[k][2], seq[k][1], seq[k][0]);
      checks++;
      if ({bus.O, bus.O_vld, bus.O_err} !== {exp_o[k], exp_v[k], 1'b0}) begin
        errors++;
        $display("FAIL pairs cyc%0d: O=%h vld=%b err=%b, want O=%h vld=%b err=0",
                 k, bus.O, bus.O_vld, bus.O_err, exp_o[k], exp_v[k]);
      end
    end
  endtask

  task automatic test_gap();
    logic [2:0] seq [6] = '{3'b111, 3'b000, 3'b010, 3'b000, 3'b101, 3'b000};
    for (int k = 0; k < 6; k++) begin
      tick(1'b1, 1'b0, seq[k][2], seq[k][1], seq[k][0]);
      checks++;
      if ({bus.O, bus.O_vld, bus.O_err} !== {eo, ev, ee}) begin
        errors++;
        $display("FAIL gap cyc%0d: O=%h vld=%b err=%b, want O=%h vld=%b err=%b",
                 k, bus.O, bus.O_vld, bus.O_err, eo, ev, ee);
      end
    end
  endtask

  task automatic test_sof_restart();
    logic [2:0] seq [4] = '{3'b111, 3'b110, 3'b101, 3'b000};
    for (int k = 0; k < 4; k++) begin
      tick(1'b1, 1'b0, seq[k][2], seq[k][1], seq[k][0]);
      checks++;
      if ({bus.O, bus.O_vld, bus.O_err} !== {eo, ev, ee}) begin
        errors++;
        $display("FAIL sof_restart cyc%0d: O=%h vld=%b err=%b, want O=%h vld=%b err=%b",
                 k, bus.O, bus.O_vld, bus.O_err, eo, ev, ee);
      end
    end
  endtask

  task automatic test_bypass();
    // Start a symbol, then enter bypass mid-symbol; then leave and send a non-sof bit.
    logic [3:0] seq [7] = '{4'b0111, 4'b1101, 4'b1100, 4'b1111, 4'b1000,
                            4'b0101, 4'b0000};
    for (int k = 0; k < 7; k++) begin
      tick(1'b1, seq[k][3], seq[k][2], seq[k][1], seq[k][0]);
      checks++;
      if ({bus.O, bus.O_vld, bus.O_err} !== {eo, ev, ee}) begin
        errors++;
        $display("FAIL bypass cyc%0d: O=%h vld=%b err=%b, want O=%h vld=%b err=%b",
                 k, bus.O, bus.O_vld, bus.O_err, eo, ev, ee);
      end
    end
  endtask

  task automatic test_gap_timeout();
    // 14 idle cycles survive, 15 time out; the trailing non-sof bit is dropped.
    for (int run = 14; run <= 15; run++) begin
      tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      for (int k = 0; k <= run; k++) begin
        if (k < run) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        else         tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++;
        if ({bus.O, bus.O_vld, bus.O_err} !== {eo, ev, ee}) begin
          errors++;
          $display("FAIL gap_timeout run%0d cyc%0d: O=%h vld=%b err=%b, want O=%h vld=%b err=%b",
                   run, k, bus.O, bus.O_vld, bus.O_err, eo, ev, ee);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] seq [6] = '{4'b1111, 4'b0000, 4'b1101, 4'b1111, 4'b1100, 4'b1000};
    for (int k = 0; k < 6; k++) begin
      tick(seq[k][3], 1'b0, seq[k][2], seq[k][1], seq[k][0]);
      checks++;
      if ({bus.O, bus.O_vld, bus.O_err} !== {eo, ev, ee}) begin
        errors++;
        $display("FAIL reset_mid cyc%0d: O=%h vld=%b err=%b, want O=%h vld=%b err=%b",
                 k, bus.O, bus.O_vld, bus.O_err, eo, ev, ee);
      end
    end
  endtask

  task automatic test_random();
    bit r, bp, v, s, i;
    bp = 1'b0;
    for (int k = 0; k < 1200; k++) begin
      r = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 29) == 0) bp = ~bp;
      // Sparse valid in the second half so gap timeouts get exercised.
      v = (k < 600) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 11) == 0);
      s = ($urandom_range(0, 2) == 0);
      i = 1'($urandom);
      tick(r, bp, v, s, i);
      checks++;
      if ({bus.O, bus.O_vld, bus.O_err} !== {eo, ev, ee} || (bus.O_vld && bus.O_err)) begin
        errors++;
        $display("FAIL random cyc%0d: O=%h vld=%b err=%b, want O=%h vld=%b err=%b",
                 k, bus.O, bus.O_vld, bus.O_err, eo, ev, ee);
      end
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    mgap       = 0;
    eo         = '0;
    ev         = 1'b0;
    ee         = 1'b0;
    rst_n      = 1'b0;
    bus.bypass = 1'b0;
    bus.I      = 1'b0;
    bus.I_vld  = 1'b0;
    bus.I_sof  = 1'b0;
    test_reset();
    test_pairs();
    test_gap();
    test_sof_restart();
    test_bypass();
    test_gap_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
